// File: rtl/regfile_wb_pkg.sv
// Shared types and default widths for the register-file writeback path.
package regfile_wb_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH    = 32;

  typedef struct packed {
    logic                         valid;
    logic [DEF_ADDRESS_WIDTH-1:0] rd;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue: circular buffer with head/tail pointers, occupancy count
// and per-entry valid bits; all entries are exposed for destination decode.
module regfile_wb_queue
  import regfile_wb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enq,
  input  logic [ADDRESS_WIDTH-1:0]              enq_rd,
  input  logic [DATA_WIDTH-1:0]                 enq_data,
  input  logic                                  deq,
  output logic [$clog2(DEPTH)-1:0]              head_ptr,
  output logic [$clog2(DEPTH):0]                count,
  output logic [DEPTH-1:0]                      ent_valid,
  output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0]   ent_rd,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]      ent_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]                    head_q, head_d;
  logic [PTR_W-1:0]                    tail_q, tail_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic [DEPTH-1:0]                    valid_q, valid_d;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    data_q, data_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    // Dequeue is applied first so a full-queue enq+deq into the same slot keeps the new entry.
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      rd_d[tail_q]    = enq_rd;
      data_d[tail_q]  = enq_data;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign head_ptr  = head_q;
  assign count     = count_q;
  assign ent_valid = valid_q;
  assign ent_rd    = rd_q;
  assign ent_data  = data_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port owner: arbitrates ALU/LSU results into an in-order queue and drains
// one write per cycle. Optional forwarding ports are enabled by REGFILE_WRITEBACK_FWD_EN.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  output logic                          alu_ready,
  input  logic                          lsu_valid,
  input  logic [ADDRESS_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]         lsu_data,
  output logic                          lsu_ready,
  input  logic                          wb_hold,
`ifdef REGFILE_WRITEBACK_FWD_EN
  input  logic [ADDRESS_WIDTH-1:0]      fwd_ad1,
  input  logic [ADDRESS_WIDTH-1:0]      fwd_ad2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2,
  output logic [DATA_WIDTH-1:0]         fwd_data1,
  output logic [DATA_WIDTH-1:0]         fwd_data2,
`endif
  output logic                          WE3,
  output logic [ADDRESS_WIDTH-1:0]      AD3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic [(2**ADDRESS_WIDTH)-1:0] pending,
  output logic                          full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]                    head_ptr;
  logic [CNT_W-1:0]                    count;
  logic [DEPTH-1:0]                    ent_valid;
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] ent_rd;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    ent_data;

  logic                     deq;
  logic                     space;
  logic                     accept;
  logic                     enq;
  wb_src_e                  src;
  logic [ADDRESS_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]    sel_data;

  always_comb begin
    deq       = (count != '0) && !wb_hold;
    space     = (count < DEPTH_C) || deq;
    lsu_ready = space;
    alu_ready = space && !lsu_valid;
    src       = lsu_valid ? SRC_LSU : SRC_ALU;
    sel_rd    = (src == SRC_LSU) ? lsu_rd : alu_rd;
    sel_data  = (src == SRC_LSU) ? lsu_data : alu_data;
    accept    = (lsu_valid && lsu_ready) || (alu_valid && alu_ready);
    // Writes to x0 are handshaken but dropped so they never occupy a slot.
    enq       = accept && (sel_rd != '0);
  end

  regfile_wb_queue #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq),
    .enq_rd    (sel_rd),
    .enq_data  (sel_data),
    .deq       (deq),
    .head_ptr  (head_ptr),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd),
    .ent_data  (ent_data)
  );

  always_comb begin
    WE3  = deq;
    AD3  = (count != '0) ? ent_rd[head_ptr] : '0;
    WD3  = (count != '0) ? ent_data[head_ptr] : '0;
    full = (count == DEPTH_C);
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ent_valid[i]) pending[ent_rd[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

`ifdef REGFILE_WRITEBACK_FWD_EN
  // Walks entries oldest to youngest so the last match is the youngest; returns {hit, data}.
  function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDRESS_WIDTH-1:0] ad);
    logic [PTR_W-1:0] idx;
    logic [DATA_WIDTH:0] res;
    res = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head_ptr + PTR_W'(k);
      if (ent_valid[idx] && (ent_rd[idx] == ad) && (ad != '0)) begin
        res = {1'b1, ent_data[idx]};
      end
    end
    return res;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_ad1);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_ad2);
  end
`endif

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side producer for the 32-entry register file; owns the single write port (AD3/WE3/WD3).
- Accepts results from two sources, ALU (single-cycle) and LSU (multi-cycle loads), over valid/ready, and arbitrates between them.
- Buffers accepted results in an in-order queue and drains one write per cycle unless held.
- Publishes a pending-destination vector so issue logic can stall on RAW hazards.

Parameters:
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers)
- DATA_WIDTH, 32, result/register data width
- DEPTH, 4, writeback queue entries (power of two, >=2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU result valid
- alu_rd  input  ADDRESS_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- alu_ready  output  1  ALU result accepted this cycle
- lsu_valid  input  1  load result valid
- lsu_rd  input  ADDRESS_WIDTH  load destination register
- lsu_data  input  DATA_WIDTH  load data
- lsu_ready  output  1  load result accepted this cycle
- wb_hold  input  1  block queue drain (write port borrowed)
- WE3  output  1  register file write enable
- AD3  output  ADDRESS_WIDTH  register file write address
- WD3  output  DATA_WIDTH  register file write data
- pending  output  2**ADDRESS_WIDTH  bit r set while any queued entry targets r
- full  output  1  queue holds DEPTH entries

Behaviour:
- Reset (async, rst_n=0): head, tail and count cleared to 0; all entries invalid; WE3=0, AD3=0, WD3=0, pending=0, full=0. Reset mid-operation discards all queued writes; no partial write is issued.
- Queue: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0; count of width log2(DEPTH)+1.
- Drain: deq = (count!=0) && !wb_hold.
  - WE3=deq. AD3/WD3 = head entry when count!=0, else 0. All three are combinational from queue state.
  - Write commits in the register file at the next clk edge; head advances on that same edge.
- Space: space = (count<DEPTH) || deq. Simultaneous enqueue and dequeue on a full queue is allowed; count is unchanged.
- Arbitration: at most one enqueue per cycle; LSU has fixed priority.
  - lsu_ready = space.
  - alu_ready = space && !lsu_valid.
  - A source whose valid is high and ready is low holds rd/data stable.
- x0 filter: an accepted result with rd==0 is handshaken (ready high) but not enqueued; count, pending and WE3 are unaffected. It consumes that cycle's arbitration slot.
- Latency: result accepted at edge N -> WE3=1 in the cycle after edge N (queue empty, no hold) -> register visible for read after edge N+1.
- Order: writes issue strictly in acceptance order; two queued writes to the same rd commit oldest first.
- pending[r] = OR over valid entries of (entry.rd==r). pending[0] is always 0. The bit clears on the edge that drains the last entry for r.
- full = (count==DEPTH).

Optional Feature:
- Macro: REGFILE_WRITEBACK_FWD_EN.
- Defined: adds inputs fwd_ad1, fwd_ad2 (ADDRESS_WIDTH each) and outputs fwd_hit1, fwd_hit2 (1) and fwd_data1, fwd_data2 (DATA_WIDTH).
  - fwd_hitN=1 when a valid queued entry has rd==fwd_adN and fwd_adN!=0.
  - fwd_dataN = data of the youngest matching entry, else 0.
  - Purely combinational from queue state; the entry being drained this cycle still forwards.
- Undefined: ports and logic absent; consumers stall on pending.

Decomposition:
- Package regfile_wb_pkg: ADDRESS_WIDTH/DATA_WIDTH default constants; wb_entry_t struct {valid, rd, data}; wb_src_e enum {SRC_ALU, SRC_LSU}.
- Sub-module regfile_wb_queue: circular buffer, pointers, count and per-entry valid, exposing head and an entry array for pending/forward decode.
- Top level holds arbitration, x0 filter, port mapping and optional forwarding.

Test Plan:
- Single ALU write: alu_valid=1, rd=5, data=0xDEADBEEF for one cycle -> next cycle WE3=1, AD3=5, WD3=0xDEADBEEF; pending[5]=1 for exactly that cycle; register 5 reads 0xDEADBEEF afterwards.
- Same-cycle conflict: lsu rd=3 data=0x11 and alu rd=4 data=0x22 together -> lsu_ready=1, alu_ready=0; writes to r3 then r4 on consecutive cycles.
- Fill/hold: wb_hold=1, push 4 results rd=1..4 -> full=1, ready=0 on a 5th push. Release hold -> four writes in order; a 5th push in the first drain cycle is accepted.
- x0 drop: alu rd=0 data=0xFFFFFFFF -> alu_ready=1, WE3 stays 0, count unchanged, pending=0.
- Reset mid-queue: hold with 3 entries, pulse rst_n low mid-cycle -> WE3/AD3/WD3/pending/full=0 immediately; no writes after release.
- With REGFILE_WRITEBACK_FWD_EN: hold, queue rd=7 0xA then rd=7 0xB; fwd_ad1=7 -> fwd_hit1=1, fwd_data1=0xB; fwd_ad2=0 -> fwd_hit2=0.
